// File: rtl/frame_dump_ctrl.sv
// Frame dump controller: captures one camera frame (or every frame in continuous mode)
// into an internal buffer with runtime pixel decimation, then streams it out byte-wise
// through a UART start/busy handshake, preceded by a 3-byte sync/length header.
//
// Ports:
//   dump_clk, dump_reset_n   clock, asynchronous active-low reset
//   arm, abort               one-cycle control pulses (abort wins over arm)
//   mode, decim              continuous-mode select and decimation, latched on arm
//   frame_start, frame_end   frame delimiters from the capture front end
//   pix_valid, pix_data      pixel stream
//   tx_start, tx_data        one-cycle byte request and held byte to the UART
//   tx_status                UART busy
//   busy, overflow           not-idle flag, sticky buffer-full flag (cleared on arm)
//   word_count               words stored in the last/current capture
module frame_dump_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              dump_clk,
  input  logic              dump_reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              mode,
  input  logic [3:0]        decim,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_status,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CountOne  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle, StWaitSof, StCapture, StSendHdr, StSendData, StDone
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [3:0]        decim_q, decim_d;
  logic [3:0]        dec_cnt_q, dec_cnt_d;
  logic [ADDR_W:0]   wcount_q, wcount_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [1:0]        hdr_idx_q, hdr_idx_d;
  logic              byte_sel_q, byte_sel_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              out_q, out_d;        // a byte is outstanding at the UART
  logic              seen_busy_q, seen_busy_d;
  logic              mem_we;
  logic              issue_ok;
  logic [15:0]       rd_word;
  logic [15:0]       wc16;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rd_data_q;

  // Write address is the running word count; the read port free-runs on rd_cnt so the
  // next word is already in rd_data_q long before the current byte's handshake ends.
  always_ff @(posedge dump_clk) begin
    if (mem_we) begin
      mem[wcount_q[ADDR_W-1:0]] <= pix_data;
    end
    rd_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
  end

  assign rd_word  = 16'(rd_data_q);
  assign wc16     = 16'(wcount_q);
  assign issue_ok = !out_q && !tx_start_q && !tx_status && !abort;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    decim_d     = decim_q;
    dec_cnt_d   = dec_cnt_q;
    wcount_d    = wcount_q;
    ovf_d       = ovf_q;
    rd_cnt_d    = rd_cnt_q;
    hdr_idx_d   = hdr_idx_q;
    byte_sel_d  = byte_sel_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    out_d       = out_q;
    seen_busy_d = seen_busy_q;
    mem_we      = 1'b0;

    // Outstanding byte retires once the UART has been seen busy and then idle again.
    if (out_q) begin
      if (tx_status) begin
        seen_busy_d = 1'b1;
      end else if (seen_busy_q) begin
        out_d       = 1'b0;
        seen_busy_d = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d  = StWaitSof;
          mode_d   = mode;
          decim_d  = decim;
          ovf_d    = 1'b0;
          wcount_d = '0;
          rd_cnt_d = '0;
        end
      end
      StWaitSof: begin
        if (frame_start) begin
          state_d   = StCapture;
          dec_cnt_d = '0;
        end
      end
      StCapture: begin
        if (pix_valid) begin
          dec_cnt_d = (dec_cnt_q == decim_q) ? 4'd0 : dec_cnt_q + 4'd1;
          if (dec_cnt_q == 4'd0) begin
            if (wcount_q == FullCount) begin
              ovf_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              wcount_d = wcount_q + CountOne;
            end
          end
        end
        // A frame_start here means the end was missed; close this frame with it.
        if (frame_end || frame_start) begin
          state_d    = StSendHdr;
          hdr_idx_d  = 2'd0;
          rd_cnt_d   = '0;
          byte_sel_d = 1'b0;
        end
      end
      StSendHdr: begin
        if (hdr_idx_q == 2'd3) begin
          // Only reached for an empty frame: wait for the last header handshake.
          if (!out_q) begin
            state_d = StDone;
          end
        end else if (issue_ok) begin
          tx_start_d  = 1'b1;
          out_d       = 1'b1;
          seen_busy_d = 1'b0;
          hdr_idx_d   = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd0:    tx_data_d = SYNC_BYTE;
            2'd1:    tx_data_d = wc16[15:8];
            default: tx_data_d = wc16[7:0];
          endcase
          if (hdr_idx_q == 2'd2 && wcount_q != '0) begin
            state_d = StSendData;
          end
        end
      end
      StSendData: begin
        if (rd_cnt_q == wcount_q) begin
          if (!out_q) begin
            state_d = StDone;
          end
        end else if (issue_ok) begin
          tx_start_d  = 1'b1;
          out_d       = 1'b1;
          seen_busy_d = 1'b0;
          if (DATA_W == 16 && !byte_sel_q) begin
            tx_data_d  = rd_word[15:8];
            byte_sel_d = 1'b1;
          end else begin
            tx_data_d  = rd_word[7:0];
            byte_sel_d = 1'b0;
            rd_cnt_d   = rd_cnt_q + CountOne;
          end
        end
      end
      StDone: begin
        if (mode_q) begin
          state_d  = StWaitSof;
          wcount_d = '0;
          rd_cnt_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort keeps the capture results; issue_ok already blocks any new byte.
    if (abort) begin
      state_d  = StIdle;
      mode_d   = mode_q;
      decim_d  = decim_q;
      wcount_d = wcount_q;
      ovf_d    = ovf_q;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge dump_clk or negedge dump_reset_n) begin
    if (!dump_reset_n) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      decim_q     <= 4'd0;
      dec_cnt_q   <= 4'd0;
      wcount_q    <= '0;
      ovf_q       <= 1'b0;
      rd_cnt_q    <= '0;
      hdr_idx_q   <= 2'd0;
      byte_sel_q  <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      out_q       <= 1'b0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      decim_q     <= decim_d;
      dec_cnt_q   <= dec_cnt_d;
      wcount_q    <= wcount_d;
      ovf_q       <= ovf_d;
      rd_cnt_q    <= rd_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      byte_sel_q  <= byte_sel_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      out_q       <= out_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = (state_q != StIdle);
  assign overflow   = ovf_q;
  assign word_count = wcount_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Bench for frame_dump_ctrl: an 8-bit instance (depth 1024) and a 16-bit instance
// (depth 4) share one stimulus stream. Each has its own UART model (busy 4 cycles per
// byte) and an expected-byte queue popped by a monitor whenever tx_start is seen.
module tb_frame_dump_ctrl;

  typedef logic [7:0] bytes_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, abort, mode;
  logic [3:0]  decim;
  logic        fs, fe, pv;
  logic [15:0] pd;

  logic        ts8, ts16;
  logic [7:0]  td8, td16;
  logic        st8 = 1'b0, st16 = 1'b0;
  logic        busy8, busy16, ovf8, ovf16;
  logic [10:0] wc8;
  logic [2:0]  wc16;

  logic [7:0]  exp8[$];
  logic [7:0]  exp16[$];
  int          n_chk = 0, n_pass = 0;
  int          cnt8 = 0, cnt16 = 0;
  int          b8, b16;

  always #5 clk = ~clk;

  frame_dump_ctrl #(.DATA_W(8), .ADDR_W(10), .SYNC_BYTE(8'hA5)) u8 (
    .dump_clk(clk), .dump_reset_n(rst_n), .arm(arm), .abort(abort), .mode(mode),
    .decim(decim), .frame_start(fs), .frame_end(fe), .pix_valid(pv), .pix_data(pd[7:0]),
    .tx_start(ts8), .tx_data(td8), .tx_status(st8), .busy(busy8), .overflow(ovf8),
    .word_count(wc8)
  );

  frame_dump_ctrl #(.DATA_W(16), .ADDR_W(2), .SYNC_BYTE(8'hA5)) u16 (
    .dump_clk(clk), .dump_reset_n(rst_n), .arm(arm), .abort(abort), .mode(mode),
    .decim(decim), .frame_start(fs), .frame_end(fe), .pix_valid(pv), .pix_data(pd),
    .tx_start(ts16), .tx_data(td16), .tx_status(st16), .busy(busy16), .overflow(ovf16),
    .word_count(wc16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
  endtask

  task automatic push(input int w, input bytes_t b);
    foreach (b[i]) begin
      if (w == 8) exp8.push_back(b[i]);
      else exp16.push_back(b[i]);
    end
  endtask

  task automatic cyc(input logic s, input logic e, input logic v, input logic [15:0] d);
    @(negedge clk);
    fs = s; fe = e; pv = v; pd = d;
  endtask

  task automatic do_arm(input logic m, input logic [3:0] dc);
    @(negedge clk);
    arm = 1'b1; mode = m; decim = dc;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy8 || busy16 || exp8.size() != 0 || exp16.size() != 0) && n < 4000);
    chk(nm, 32'(n < 4000), 1);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp8.size() != 0 || exp16.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < 4000), 1);
    repeat (12) @(negedge clk);
  endtask

  // UART models: busy for 4 cycles after each accepted tx_start.
  initial begin
    int c8 = 0, c16 = 0;
    forever begin
      @(posedge clk);
      if (c8 != 0) begin c8--; st8 <= (c8 != 0); end
      else if (ts8) begin c8 = 4; st8 <= 1'b1; end
      if (c16 != 0) begin c16--; st16 <= (c16 != 0); end
      else if (ts16) begin c16 = 4; st16 <= 1'b1; end
    end
  end

  // Monitor: pop and compare whenever a DUT presents a byte.
  initial forever begin
    @(negedge clk);
    if (rst_n && ts8) begin
      cnt8++;
      chk("tx8_uart_idle", 32'(st8), 0);
      if (exp8.size() == 0) begin
        n_chk++;
        $display("FAIL tx8_byte: got 0x%0h required no byte", td8);
      end else chk("tx8_byte", 32'(td8), 32'(exp8.pop_front()));
    end
    if (rst_n && ts16) begin
      cnt16++;
      chk("tx16_uart_idle", 32'(st16), 0);
      if (exp16.size() == 0) begin
        n_chk++;
        $display("FAIL tx16_byte: got 0x%0h required no byte", td16);
      end else chk("tx16_byte", 32'(td16), 32'(exp16.pop_front()));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; mode = 1'b0; decim = 4'd0;
    fs = 1'b0; fe = 1'b0; pv = 1'b0; pd = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 0);     chk("rst_busy16", 32'(busy16), 0);
    chk("rst_ovf8", 32'(ovf8), 0);       chk("rst_ovf16", 32'(ovf16), 0);
    chk("rst_wc8", 32'(wc8), 0);         chk("rst_wc16", 32'(wc16), 0);
    chk("rst_txs8", 32'(ts8), 0);        chk("rst_txs16", 32'(ts16), 0);
    chk("rst_txd8", 32'(td8), 0);        chk("rst_txd16", 32'(td16), 0);
    @(negedge clk) rst_n = 1'b1;

    // One-shot, 5 pixels; the depth-4 instance overflows.
    push(8,  '{8'hA5, 8'h00, 8'h05, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
    push(16, '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h10, 8'h00, 8'h11, 8'h00, 8'h12, 8'h00, 8'h13});
    do_arm(1'b0, 4'd0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'(32'h10 + i));
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    wait_idle("s1_done");
    chk("s1_wc8", 32'(wc8), 5);   chk("s1_wc16", 32'(wc16), 4);
    chk("s1_ovf8", 32'(ovf8), 0); chk("s1_ovf16", 32'(ovf16), 1);

    // decim=2 over 0..8 stores 0,3,6; traffic before frame_start is ignored.
    push(8,  '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h03, 8'h06});
    push(16, '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h06});
    do_arm(1'b0, 4'd2);
    cyc(0, 1, 1, 16'h0077);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 16'(i));
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    wait_idle("s2_done");
    chk("s2_wc8", 32'(wc8), 3);   chk("s2_wc16", 32'(wc16), 3);
    chk("s2_ovf16_cleared", 32'(ovf16), 0);

    // 16-bit words go out MSB first.
    push(8,  '{8'hA5, 8'h00, 8'h02, 8'h34, 8'hCD});
    push(16, '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
    do_arm(1'b0, 4'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'h1234);
    cyc(0, 0, 1, 16'hABCD);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    wait_idle("s3_done");
    chk("s3_wc16", 32'(wc16), 2);

    // Empty frame: header only.
    push(8,  '{8'hA5, 8'h00, 8'h00});
    push(16, '{8'hA5, 8'h00, 8'h00});
    do_arm(1'b0, 4'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    wait_idle("s5_done");
    chk("s5_wc8", 32'(wc8), 0);

    // Pixel on the frame_end cycle is stored.
    push(8,  '{8'hA5, 8'h00, 8'h02, 8'h21, 8'h22});
    push(16, '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h21, 8'h00, 8'h22});
    do_arm(1'b0, 4'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'h0021);
    cyc(0, 1, 1, 16'h0022);
    cyc(0, 0, 0, 0);
    wait_idle("s6_done");
    chk("s6_wc8", 32'(wc8), 2);   chk("s6_wc16", 32'(wc16), 2);

    // arm+abort together in idle: abort wins, count untouched.
    @(negedge clk); arm = 1'b1; abort = 1'b1;
    @(negedge clk); arm = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("armabort_busy8", 32'(busy8), 0); chk("armabort_busy16", 32'(busy16), 0);
    chk("armabort_wc8", 32'(wc8), 2);

    // Continuous mode, two frames, then abort while waiting for the third.
    push(8,  '{8'hA5, 8'h00, 8'h02, 8'h31, 8'h32});
    push(16, '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h31, 8'h00, 8'h32});
    do_arm(1'b1, 4'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'h0031);
    cyc(0, 0, 1, 16'h0032);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    wait_drain("s7_f1_drain");
    chk("s7_busy8_cont", 32'(busy8), 1); chk("s7_wc8_cleared", 32'(wc8), 0);
    b8 = cnt8; b16 = cnt16;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'h0041);
    repeat (10) cyc(0, 0, 0, 0);
    chk("s7_no_early_hdr8", 32'(cnt8), 32'(b8));
    chk("s7_no_early_hdr16", 32'(cnt16), 32'(b16));
    push(8,  '{8'hA5, 8'h00, 8'h01, 8'h41});
    push(16, '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h41});
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    wait_drain("s7_f2_drain");
    chk("s7_busy16_cont", 32'(busy16), 1);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    @(negedge clk);
    chk("s7_abort_busy8", 32'(busy8), 0); chk("s7_abort_busy16", 32'(busy16), 0);

    // Abort once the first data byte has gone out.
    b8 = cnt8;
    push(8,  '{8'hA5, 8'h00, 8'h03, 8'h51});
    push(16, '{8'hA5, 8'h00, 8'h03, 8'h00});
    do_arm(1'b0, 4'd0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'(32'h51 + i));
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    begin
      int n = 0;
      while (cnt8 < b8 + 4 && n < 4000) begin
        @(negedge clk);
        n++;
      end
      chk("s8_reach_data", 32'(cnt8 >= b8 + 4), 1);
    end
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    b8 = cnt8; b16 = cnt16;
    repeat (30) @(negedge clk);
    chk("s8_no_tx8", 32'(cnt8), 32'(b8)); chk("s8_no_tx16", 32'(cnt16), 32'(b16));
    chk("s8_busy8", 32'(busy8), 0);       chk("s8_busy16", 32'(busy16), 0);
    chk("s8_wc8_held", 32'(wc8), 3);      chk("s8_wc16_held", 32'(wc16), 3);
    chk("s8_q8_empty", 32'(exp8.size()), 0);
    chk("s8_q16_empty", 32'(exp16.size()), 0);

    // Asynchronous reset mid-capture takes effect without a clock edge.
    do_arm(1'b0, 4'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'h0061);
    cyc(0, 0, 1, 16'h0062);
    @(negedge clk);
    pv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("areset_busy8", 32'(busy8), 0);   chk("areset_wc8", 32'(wc8), 0);
    chk("areset_busy16", 32'(busy16), 0); chk("areset_wc16", 32'(wc16), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_dump_ctrl.md
Name: frame_dump_ctrl

Overview:
Parametrised successor to the disabled single-mode dump controller in the camera debug top. It captures one camera frame (or every frame, in continuous mode) into an internal buffer, with runtime pixel decimation. The frame is then streamed out byte-wise through the rsio_01a transmit handshake, preceded by a sync/length header. It sits between the camera capture front end, already retimed into this clock, and the UART.

Parameters:
DATA_W, 8, pixel word width; legal values 8 or 16. 16-bit words are sent as 2 bytes, MSB first.
ADDR_W, 10, buffer address width; depth = 2**ADDR_W words.
SYNC_BYTE, 8'hA5, first header byte.

Ports:
dump_clk  in  1  block clock
dump_reset_n  in  1  asynchronous active-low reset
arm  in  1  one-cycle pulse; start a capture when IDLE
abort  in  1  one-cycle pulse; return to IDLE from any state
mode  in  1  0 = one-shot, 1 = continuous; sampled on arm
decim  in  4  store 1 of every decim+1 valid pixels; sampled on arm
frame_start  in  1  one-cycle pulse at start of frame
frame_end  in  1  one-cycle pulse at end of frame
pix_valid  in  1  pix_data qualifier
pix_data  in  DATA_W  pixel word
tx_start  out  1  one-cycle request to UART, same meaning as TxStart of rsio_01a
tx_data  out  8  byte to transmit, valid while tx_start=1
tx_status  in  1  UART busy (1 = transmitting)
busy  out  1  high in every state except IDLE
overflow  out  1  sticky: buffer filled during capture; cleared on arm
word_count  out  ADDR_W+1  words stored in last/current capture

Behaviour:
- Reset: all outputs are 0, state is IDLE, read/write pointers are 0, and the decimation counter is 0.
- States: IDLE, WAIT_SOF, CAPTURE, SEND_HDR, SEND_DATA, DONE.
- IDLE → WAIT_SOF on arm.
  - On that transition: latch mode and decim; clear overflow and word_count.
  - arm in any other state is ignored.
- WAIT_SOF:
  - frame_end and pix_valid are ignored.
  - frame_start → CAPTURE; the decimation counter is cleared.
- CAPTURE:
  - On each pix_valid: if decimation counter == 0 and buffer not full, write pix_data at the write pointer and increment word_count.
  - The decimation counter increments per valid pixel and wraps to 0 after reaching the latched decim.
  - Full (word_count == 2**ADDR_W): further writes are dropped and overflow is set. The block stays in CAPTURE until the frame ends.
  - frame_end → SEND_HDR.
  - frame_start while in CAPTURE (missed end) → SEND_HDR; that frame_start is not re-used.
  - frame_end and pix_valid in the same cycle: the pixel is stored, then the block transitions.
- Byte issue rule, common to both SEND states:
  - tx_start is pulsed for exactly one cycle, only while tx_status == 0 and no byte is outstanding.
  - A byte is outstanding from its tx_start until tx_status has been seen 1 and then 0.
  - tx_data holds its value until the next tx_start.
  - First tx_start is asserted the cycle after entering SEND_HDR, provided tx_status == 0.
- SEND_HDR: sends 3 bytes: SYNC_BYTE, word_count[15:8] (zero-extended), word_count[7:0]. Then:
  - → SEND_DATA if word_count > 0;
  - → DONE if word_count == 0.
- SEND_DATA:
  - Reads the buffer from address 0; synchronous RAM with 1-cycle read latency, prefetched so no idle cycle is added beyond the handshake.
  - DATA_W = 16: byte order is [15:8] then [7:0] per word.
  - → DONE after the last byte's handshake completes.
- DONE:
  - mode = 0 → IDLE.
  - mode = 1 → WAIT_SOF, with word_count and pointers cleared. overflow stays set until the next arm.
- abort: → IDLE next cycle from any state.
  - tx_start is forced 0.
  - A byte already handed to the UART finishes on its own.
  - word_count and overflow hold their values.
- Simultaneous arm and abort in IDLE: abort wins and the state stays IDLE.
- Asynchronous reset mid-frame or mid-send: immediate return to reset values. Buffer contents are don't-care.

Test Plan:
- One-shot, DATA_W=8, decim=0: arm, frame of 5 valid pixels 0x10..0x14, frame_end. UART model busy 4 cycles per byte → tx bytes A5,00,05,10,11,12,13,14; busy falls after the last handshake; word_count=5.
- decim=2, 9 valid pixels 0..8 → stored 0,3,6; header A5,00,03.
- ADDR_W=2, 6 valid pixels → overflow=1, word_count=4, first 4 pixels sent. Next arm clears overflow.
- DATA_W=16: pixels 0x1234, 0xABCD → bytes A5,00,02,12,34,AB,CD.
- Continuous mode, 2 frames: second header emitted only after the second frame's frame_end. Abort during SEND_DATA → tx_start stays 0 from the next cycle and state returns to IDLE.
- Empty frame (frame_start, frame_end, no pixels) → only A5,00,00. Plus the simultaneous frame_end+pix_valid case: the last pixel is included in the count.
